// File: rtl/btn_ctrl.sv
// Push-button conditioner: per-button 2-FF synchroniser and debouncer,
// frame-aligned move levels and a rate-limited, frame-aligned fire pulse.
module btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int CD_W            = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       btn_fire_raw,
  input  logic       frame_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic [2:0] btn_state
);

  localparam int              NCH     = 3;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_FIRE  = 2;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    PENDING  = 2'd1,
    COOLDOWN = 2'd2
  } fire_state_t;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync_meta;
  logic [NCH-1:0] sync_q;
  logic [NCH-1:0] st;

  assign raw = {btn_fire_raw, btn_right_raw, btn_left_raw};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, like real flip-flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // The counter only advances while the synchronised input disagrees with
  // the accepted level; any agreement restarts the qualification window.
  for (genvar i = 0; i < NCH; i++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            st_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt  <= '0;
        st_q <= 1'b0;
      end else if (sync_q[i] == st_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        st_q <= sync_q[i];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign st[i] = st_q;
  end

  assign btn_state = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else if (frame_tick) begin
      move_left  <= st[CH_LEFT] & ~st[CH_RIGHT];
      move_right <= st[CH_RIGHT] & ~st[CH_LEFT];
    end
  end

  fire_state_t     state, state_next;
  logic [CD_W-1:0] cd, cd_next;
  logic            st_fire_q;
  logic            fire_rise;

  assign fire_rise = st[CH_FIRE] & ~st_fire_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= READY;
      cd        <= '0;
      st_fire_q <= 1'b0;
    end else begin
      state     <= state_next;
      cd        <= cd_next;
      st_fire_q <= st[CH_FIRE];
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cd_next    = cd;
    fire       = 1'b0;
    case (state)
      READY: begin
        // A press seen in a tick cycle is armed here and fires on the next tick.
        if (fire_rise) state_next = PENDING;
      end
      PENDING: begin
        if (frame_tick) begin
          fire = 1'b1;
          if (COOLDOWN_FRAMES == 0) begin
            state_next = READY;
          end else begin
            cd_next    = CD_LOAD;
            state_next = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          cd_next = cd - 1'b1;
          if (cd == CD_ONE) state_next = READY;
        end
      end
      default: state_next = READY;
    endcase
  end

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl: a vector table for the move/level mapping plus
// hand-timed sequences for debounce latency, fire cooldown and reset abort.
module tb_btn_ctrl;

  localparam int DB    = 8;
  localparam int CDF   = 3;
  localparam int FRAME = 50;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       l, r, f;
  logic       frame_tick;
  logic       move_left, move_right, fire;
  logic [2:0] btn_state;

  btn_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DB_W           (4),
    .COOLDOWN_FRAMES(CDF),
    .CD_W           (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_left_raw (l),
    .btn_right_raw(r),
    .btn_fire_raw (f),
    .frame_tick   (frame_tick),
    .move_left    (move_left),
    .move_right   (move_right),
    .fire         (fire),
    .btn_state    (btn_state)
  );

  always #5 clk = ~clk;

  int   phase       = 0;
  int   fire_pulses = 0;
  int   bad_fire    = 0;
  int   checks      = 0;
  int   passes      = 0;
  logic step_fire   = 1'b0;

  typedef struct {
    logic       l, r, f;
    logic       ml, mr;
    logic [2:0] bs;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passes++;
  endtask

  // One clock: tick is raised on the last cycle of each frame, fire is
  // sampled mid-cycle, registered outputs are read 1 ns after the edge.
  task automatic step();
    frame_tick = (phase == FRAME - 1);
    #1;
    step_fire = fire;
    if (fire) begin
      fire_pulses++;
      if (!frame_tick) bad_fire++;
    end
    @(posedge clk);
    #1;
    phase = (phase + 1) % FRAME;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_tick();
    bit seen = 1'b0;
    int n    = 0;
    while (!seen && n < FRAME + 10) begin
      seen = (phase == FRAME - 1);
      step();
      n++;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int p;

    vecs[0] = '{l:0, r:0, f:0, ml:0, mr:0, bs:3'b000};
    vecs[1] = '{l:1, r:0, f:0, ml:1, mr:0, bs:3'b001};
    vecs[2] = '{l:1, r:1, f:0, ml:0, mr:0, bs:3'b011};
    vecs[3] = '{l:0, r:1, f:0, ml:0, mr:1, bs:3'b010};
    vecs[4] = '{l:0, r:1, f:1, ml:0, mr:1, bs:3'b110};
    vecs[5] = '{l:1, r:0, f:1, ml:1, mr:0, bs:3'b101};
    vecs[6] = '{l:0, r:0, f:0, ml:0, mr:0, bs:3'b000};

    reset_n = 1'b0;
    l = 1'b0; r = 1'b0; f = 1'b0;
    frame_tick = 1'b0;
    steps(3);
    check("reset_move_left", move_left, 0);
    check("reset_move_right", move_right, 0);
    check("reset_fire", fire, 0);
    check("reset_btn_state", btn_state, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      l = vecs[i].l; r = vecs[i].r; f = vecs[i].f;
      steps(DB + 4);
      run_to_tick();
      check($sformatf("vec%0d_move_left", i), move_left, vecs[i].ml);
      check($sformatf("vec%0d_move_right", i), move_right, vecs[i].mr);
      check($sformatf("vec%0d_btn_state", i), btn_state, vecs[i].bs);
    end
    repeat (CDF + 1) run_to_tick();

    // Bounce: 3-cycle toggles never qualify; the final rise lands 10 clk later.
    for (int i = 0; i < 30; i++) begin
      l = ((i / 3) % 2 == 0);
      step();
    end
    check("bounce_no_accept", btn_state[0], 0);
    l = 1'b1;
    steps(DB + 1);
    check("bounce_st_left_early", btn_state[0], 0);
    step();
    check("bounce_st_left_rise", btn_state[0], 1);
    check("bounce_move_left_before_tick", move_left, 0);
    run_to_tick();
    check("bounce_move_left_at_tick", move_left, 1);

    // Both held, then right released.
    r = 1'b1;
    steps(DB + 4);
    run_to_tick();
    check("both_move_left", move_left, 0);
    check("both_move_right", move_right, 0);
    r = 1'b0;
    steps(DB + 2);
    check("rel_right_st", btn_state[1], 0);
    check("rel_right_move_left_wait", move_left, 0);
    run_to_tick();
    check("rel_right_move_left_tick", move_left, 1);
    l = 1'b0;
    steps(DB + 4);
    run_to_tick();
    check("rel_left_move_left", move_left, 0);

    // Fire press held for 10 frames gives exactly one pulse.
    run_to_tick();
    p = fire_pulses;
    f = 1'b1;
    steps(FRAME);
    check("press_pulse_at_tick", step_fire, 1);
    check("press_pulse_count", fire_pulses, p + 1);
    repeat (10) run_to_tick();
    check("hold_no_repeat", fire_pulses, p + 1);
    f = 1'b0;
    repeat (CDF + 1) run_to_tick();

    // Cooldown: a full press inside the first blocked frame is dropped.
    p = fire_pulses;
    f = 1'b1;
    steps(FRAME);
    check("cd_first_pulse", fire_pulses, p + 1);
    f = 1'b0; steps(15);
    f = 1'b1; steps(15);
    f = 1'b0; steps(15);
    repeat (CDF) run_to_tick();
    check("cd_press_dropped", fire_pulses, p + 1);
    f = 1'b1;
    steps(FRAME);
    check("cd_after_pulse_at_tick", step_fire, 1);
    check("cd_after_pulse_count", fire_pulses, p + 2);
    f = 1'b0;
    repeat (CDF + 1) run_to_tick();

    // Coincident tick: st_fire rises just before the tick cycle.
    p = fire_pulses;
    steps(FRAME - 11);
    f = 1'b1;
    steps(DB + 2);
    check("coinc_st_fire", btn_state[2], 1);
    step();
    check("coinc_no_fire_same_tick", step_fire, 0);
    run_to_tick();
    check("coinc_fire_next_tick", step_fire, 1);
    check("coinc_pulse_count", fire_pulses, p + 1);
    f = 1'b0;
    repeat (CDF + 1) run_to_tick();

    // Reset while PENDING aborts the pulse; FSM comes back in READY.
    p = fire_pulses;
    f = 1'b1;
    steps(DB + 3);
    reset_n = 1'b0;
    #1;
    check("midrst_btn_state", btn_state, 0);
    check("midrst_move_left", move_left, 0);
    check("midrst_move_right", move_right, 0);
    check("midrst_fire", fire, 0);
    f = 1'b0;
    steps(3);
    reset_n = 1'b1;
    run_to_tick();
    run_to_tick();
    check("midrst_no_pulse", fire_pulses, p);
    f = 1'b1;
    steps(FRAME);
    check("midrst_new_press_fires", fire_pulses, p + 1);
    f = 1'b0;

    check("fire_only_on_tick", bad_fire, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
